// File: rtl/sfp_send_scheduler.sv
// sfp_send_scheduler: per-channel packet-send command generator.
// Each channel runs its own IDLE/ARMED/FIRE/DONE machine. From the latched mode it
// produces a fixed-length cmd_send pulse with a start RAM address and a fire counter.
module sfp_send_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 25,
   parameter int CNT_W     = 32,
   parameter int PULSE_LEN = 4,
   parameter int SCNT_W    = 16
) (
   input  logic                     clk_50,
   input  logic                     rst_n,
   input  logic                     link_ready,
   input  logic [2*NUM_CH-1:0]      cfg_mode,
   input  logic [CNT_W*NUM_CH-1:0]  cfg_period,
   input  logic [CNT_W*NUM_CH-1:0]  cfg_phase,
   input  logic [ADDR_W*NUM_CH-1:0] cfg_addr,
   input  logic [NUM_CH-1:0]        data_saved,
   output logic [NUM_CH-1:0]        cmd_send,
   output logic [ADDR_W*NUM_CH-1:0] start_ram_addr,
   output logic [SCNT_W*NUM_CH-1:0] send_cnt
);

   localparam logic [1:0] MODE_OFF      = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;
   localparam logic [1:0] MODE_ECHO     = 2'b11;

   // Pulse-length down-counter only needs to hold PULSE_LEN-1
   localparam int                PCNT_W     = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_LEN - 1);
   // Shortest period that still leaves one low cycle between pulses
   localparam logic [CNT_W-1:0]  MIN_PERIOD = CNT_W'(PULSE_LEN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRE, ST_DONE} ch_state_t;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         ch_state_t          state_reg, state_next;
         logic [1:0]         mode_reg, mode_next;
         logic [CNT_W-1:0]   cnt_reg, cnt_next;
         logic [PCNT_W-1:0]  pcnt_reg, pcnt_next;
         logic               ds_reg;
         logic               cmd_reg, cmd_next;
         logic [ADDR_W-1:0]  addr_reg, addr_next;
         logic [SCNT_W-1:0]  scnt_reg, scnt_next;

         logic [1:0]         mode_in;
         logic [CNT_W-1:0]   period_in, phase_in, eff_period;
         logic [ADDR_W-1:0]  addr_in;
         logic               ds_rise, abort;

         assign mode_in    = cfg_mode[2*gi +: 2];
         assign period_in  = cfg_period[CNT_W*gi +: CNT_W];
         assign phase_in   = cfg_phase[CNT_W*gi +: CNT_W];
         assign addr_in    = cfg_addr[ADDR_W*gi +: ADDR_W];
         assign eff_period = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
         assign ds_rise    = data_saved[gi] & ~ds_reg;
         // Leaving IDLE commits the channel to the latched mode; any change or link loss aborts
         assign abort      = (state_reg != ST_IDLE) && (!link_ready || (mode_in != mode_reg));

         // State and datapath registers; ds_reg always tracks data_saved for edge detection
         always_ff @(posedge clk_50 or negedge rst_n) begin
            if (!rst_n) begin
               state_reg <= ST_IDLE;
               mode_reg  <= MODE_OFF;
               cnt_reg   <= '0;
               pcnt_reg  <= '0;
               ds_reg    <= 1'b0;
               cmd_reg   <= 1'b0;
               addr_reg  <= '0;
               scnt_reg  <= '0;
            end else begin
               state_reg <= state_next;
               mode_reg  <= mode_next;
               cnt_reg   <= cnt_next;
               pcnt_reg  <= pcnt_next;
               ds_reg    <= data_saved[gi];
               cmd_reg   <= cmd_next;
               addr_reg  <= addr_next;
               scnt_reg  <= scnt_next;
            end
         end

         // Next-state decision for the channel
         always_comb begin
            state_next = state_reg;
            if (abort) begin
               state_next = ST_IDLE;
            end else begin
               case (state_reg)
                  ST_IDLE: begin
                     if (link_ready && (mode_in != MODE_OFF))
                        state_next = ST_ARMED;
                  end
                  ST_ARMED: begin
                     if (mode_reg == MODE_ECHO) begin
                        if (ds_rise)
                           state_next = ST_FIRE;
                     end else if (cnt_reg == '0) begin
                        state_next = ST_FIRE;
                     end
                  end
                  ST_FIRE: begin
                     if (pcnt_reg == '0)
                        state_next = (mode_reg == MODE_PERIODIC) ? ST_ARMED : ST_DONE;
                  end
                  ST_DONE: begin
                     // ECHO re-arms only after data_saved has been released
                     if ((mode_reg == MODE_ECHO) && !data_saved[gi])
                        state_next = ST_ARMED;
                  end
                  default: state_next = ST_IDLE;
               endcase
            end
         end

         // Outputs and counters; cmd_send is registered from the next state so it never glitches
         always_comb begin
            mode_next = mode_reg;
            cnt_next  = cnt_reg;
            pcnt_next = pcnt_reg;
            addr_next = addr_reg;
            scnt_next = scnt_reg;
            cmd_next  = (state_next == ST_FIRE);
            if ((state_reg == ST_IDLE) && (state_next == ST_ARMED)) begin
               mode_next = mode_in;
               cnt_next  = phase_in;
            end else if ((state_reg != ST_FIRE) && (state_next == ST_FIRE)) begin
               addr_next = addr_in;
               scnt_next = scnt_reg + SCNT_W'(1);
               cnt_next  = eff_period - CNT_W'(1);
               pcnt_next = PULSE_LAST;
            end else if (state_next != ST_IDLE) begin
               // Period counter keeps running through the pulse so fire spacing is exact
               cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
               if ((state_reg == ST_FIRE) && (pcnt_reg != '0))
                  pcnt_next = pcnt_reg - PCNT_W'(1);
            end
         end

         assign cmd_send[gi]                         = cmd_reg;
         assign start_ram_addr[ADDR_W*gi +: ADDR_W]  = addr_reg;
         assign send_cnt[SCNT_W*gi +: SCNT_W]        = scnt_reg;
      end
   endgenerate

endmodule
